// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared opcodes, states and control-word layout for the SAP-1 controller
package sap1_pkg;

    localparam int CTRL_W = 13;

    // Control-word bit positions, MSB first
    localparam int PC_OE   = 12;
    localparam int PC_IE   = 11;
    localparam int PC_STEP = 10;
    localparam int MAR_IE  = 9;
    localparam int RAM_OE  = 8;
    localparam int IR_IE   = 7;
    localparam int IR_OE   = 6;
    localparam int A_IE    = 5;
    localparam int A_OE    = 4;
    localparam int B_IE    = 3;
    localparam int ALU_OE  = 2;
    localparam int ALU_SUB = 1;
    localparam int OUT_IE  = 0;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        T0   = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        T4   = 3'd4,
        T5   = 3'd5,
        HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        K_LDA,
        K_ADD,
        K_SUB,
        K_JMP,
        K_OUT,
        K_HLT,
        K_NOP
    } op_kind_t;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/sap1_if.sv
// rtl/sap1_if.sv - state/opcode to control-word link between the state register and the microcode decoder
interface sap1_if #(
    parameter int OPCODE_W = 4
) ();
    import sap1_pkg::*;

    state_t              state;
    logic [OPCODE_W-1:0] opcode;
    logic [CTRL_W-1:0]   ctrl;
    state_t              next_state;

    modport master (
        output state,
        output opcode,
        input  ctrl,
        input  next_state
    );

    modport slave (
        input  state,
        input  opcode,
        output ctrl,
        output next_state
    );

endinterface

// File: rtl/sap1_microcode.sv
// rtl/sap1_microcode.sv - pure combinational microcode: (state, opcode) -> control word and next state
module sap1_microcode
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    sap1_if.slave uc
);

    op_kind_t kind;

    always_comb begin
        kind = K_NOP;
        if (uc.opcode == OPCODE_W'(OP_LDA))      kind = K_LDA;
        else if (uc.opcode == OPCODE_W'(OP_ADD)) kind = K_ADD;
        else if (uc.opcode == OPCODE_W'(OP_SUB)) kind = K_SUB;
        else if (uc.opcode == OPCODE_W'(OP_JMP)) kind = K_JMP;
        else if (uc.opcode == OPCODE_W'(OP_OUT)) kind = K_OUT;
        else if (uc.opcode == OPCODE_W'(OP_HLT)) kind = K_HLT;
    end

    // Fetch states ignore the opcode; it is only meaningful once the IR has loaded
    always_comb begin
        uc.ctrl       = '0;
        uc.next_state = T0;
        case (uc.state)
            T0: begin
                uc.ctrl       = cbit(PC_OE) | cbit(MAR_IE);
                uc.next_state = T1;
            end
            T1: begin
                uc.ctrl       = cbit(PC_STEP);
                uc.next_state = T2;
            end
            T2: begin
                uc.ctrl       = cbit(RAM_OE) | cbit(IR_IE);
                uc.next_state = T3;
            end
            T3: begin
                case (kind)
                    K_LDA, K_ADD, K_SUB: begin
                        uc.ctrl       = cbit(IR_OE) | cbit(MAR_IE);
                        uc.next_state = T4;
                    end
                    K_JMP:   uc.ctrl  = cbit(IR_OE) | cbit(PC_IE);
                    K_OUT:   uc.ctrl  = cbit(A_OE) | cbit(OUT_IE);
                    K_HLT:   uc.next_state = HALT;
                    default: uc.ctrl  = '0;
                endcase
            end
            T4: begin
                case (kind)
                    K_LDA: uc.ctrl = cbit(RAM_OE) | cbit(A_IE);
                    K_ADD: begin
                        uc.ctrl       = cbit(RAM_OE) | cbit(B_IE);
                        uc.next_state = T5;
                    end
                    K_SUB: begin
                        uc.ctrl       = cbit(RAM_OE) | cbit(B_IE) | cbit(ALU_SUB);
                        uc.next_state = T5;
                    end
                    default: uc.ctrl = '0;
                endcase
            end
            T5: begin
                case (kind)
                    K_ADD:   uc.ctrl = cbit(ALU_OE) | cbit(A_IE);
                    K_SUB:   uc.ctrl = cbit(ALU_OE) | cbit(A_IE) | cbit(ALU_SUB);
                    default: uc.ctrl = '0;
                endcase
            end
            HALT:    uc.next_state = HALT;
            default: uc.next_state = T0;
        endcase
    end

endmodule

// File: rtl/sap1_controller.sv
// rtl/sap1_controller.sv - SAP-1 control sequencer: T-state register, reset gating, debug outputs
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [2:0]          tstate,
    output logic                halted
);

    state_t state_q;
    state_t state_d;

    sap1_if #(.OPCODE_W(OPCODE_W)) uc_bus ();

    assign uc_bus.state  = state_q;
    assign uc_bus.opcode = opcode;
    assign state_d       = uc_bus.next_state;

    sap1_microcode #(.OPCODE_W(OPCODE_W)) u_microcode (
        .uc (uc_bus)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= T0;
        else     state_q <= state_d;
    end

    // Gate during reset so the negedge-loading datapath sees no loads or counts
    assign ctrl   = rst ? '0 : uc_bus.ctrl;
    assign tstate = state_q;
    assign halted = (state_q == HALT);

endmodule
